mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the Single_Cycle_Top data-memory bus, downstream of the core.

---
 rtl/mmio_uart_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the core data-memory bus.
// Stores to TX_ADDR queue a byte in a small FIFO. A serializer shifts each
// byte out as 8N1, LSB first. Loads from STAT_ADDR return FIFO/overflow status.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit (8E1) and sets RD[3].
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_1004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        tx,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          ovf_q;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef UART_PARITY_EN
  logic          par_q;
`endif

  logic       empty, full, wr_sel, clr, baud_done, pop, push;
  logic [7:0] head;
  logic       unused_wd;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_sel    = WE && (A == TX_ADDR);
  assign clr       = WE && (A == STAT_ADDR) && WD[2];
  assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
  // The serializer takes a byte when idle, or at the last clock of STOP so frames run gap-free.
  assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));
  // A pop on the same edge frees a slot, so a store to a full FIFO still lands.
  assign push      = wr_sel && (!full || pop);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign unused_wd = ^WD[31:8];

  assign tx   = tx_q;
  assign busy = !empty || (state_q != S_IDLE);

  // Status read: pure address decode, independent of WE.
  always_comb begin
    RD = '0;
    if (A == STAT_ADDR) RD = {28'b0, PAR_EN, ovf_q, full, empty};
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= WD[7:0];
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_sel && full && !pop) ovf_q <= 1'b1;
      else if (clr)               ovf_q <= 1'b0;
    end
  end

  // Serializer FSM with registered tx so the line never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= baud_done ? '0 : baud_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            shift_q <= head;
`ifdef UART_PARITY_EN
            par_q   <= ^head;
`endif
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PAR;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        S_PAR: begin
          if (baud_done) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= head;
`ifdef UART_PARITY_EN
              par_q   <= ^head;
`endif
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule
